keycode_event_tracker: RTL
==========================

# keycode_event_tracker

Parametrised successor to the single-keycode hex path. It takes the multi-slot keycode snapshot exported by the NIOS keyboard SoC and turns slot-level changes into discrete press, release and typematic-repeat events. Events are buffered in a FIFO behind a valid/ready interface. The block sits between the SoC keycode PIO and any game or control logic, so consumers never miss a short keystroke and never compare raw snapshots.

## Interface
- NUM_SLOTS, 2, number of keycode slots in the snapshot (≥1)
- CODE_W, 8, width of one keycode; code 0 means empty slot
- FIFO_DEPTH, 8, event FIFO entries (power of 2, ≥2)
- REPEAT_DELAY, 25_000_000, idle cycles from arming to first repeat (≥1)
- REPEAT_RATE, 2_500_000, idle cycles between subsequent repeats (≥1)
- Clk  in  1  system clock; only clock in the block
- Reset  in  1  asynchronous, active-high reset
- keycode  in  NUM_SLOTS*CODE_W  snapshot from the SoC PIO; slot i is bits [i*CODE_W +: CODE_W]
- ev_valid  out  1  FIFO non-empty
- ev_data  out  2+CODE_W  {type[1:0], code}; type 01 press, 10 release, 11 repeat
- ev_ready  in  1  consumer pops the head when ev_valid && ev_ready
- overflow  out  1  sticky; an event was dropped because the FIFO was full
- ovf_clr  in  1  clears overflow (set wins if set and clear coincide)
- any_down  out  1  prev snapshot holds at least one non-zero code

## Operation
- Registers: prev[NUM_SLOTS], cur[NUM_SLOTS], scan index, FSM, repeat code, repeat counter, repeat phase (first/steady), armed flag.
- FSM states: IDLE, SCAN_REL, SCAN_PRS.
- IDLE:
  - If keycode != prev, latch cur <= keycode, set index to 0 and go to SCAN_REL. The repeat counter holds this cycle.
  - Otherwise, if armed, count. A repeat is pushed on the cycle the count reaches REPEAT_DELAY (first phase) or REPEAT_RATE (steady phase). The counter then clears and the phase becomes steady.
- SCAN_REL, one slot per cycle, i = 0..NUM_SLOTS-1:
  - Push release(prev[i]) if prev[i] != 0, no j < i has prev[j] == prev[i], and prev[i] is not in cur.
  - If prev[i] equals the repeat code, disarm.
- SCAN_PRS, i = 0..NUM_SLOTS-1:
  - Push press(cur[i]) under the same rule with prev and cur swapped.
  - Each press re-arms repeat with that code, resets the counter and sets phase to first. The highest-index press therefore wins.
  - After the last slot: prev <= cur, go to IDLE.
- keycode changes during a scan are ignored; they are caught by the compare on return to IDLE.
- FIFO rules:
  - Push into a full FIFO drops the event and sets overflow. The dropped press still arms repeat.
  - A push and a pop in the same cycle while full are both accepted.
- any_down is an OR-reduce of prev != 0.

## Timing
- Reset values: all outputs 0, prev/cur = 0, FIFO empty, state IDLE, disarmed, counter 0.
- Change detected in IDLE at cycle t:
  - The release slot-i decision happens in cycle t+1+i.
  - The press slot-i decision happens in cycle t+1+NUM_SLOTS+i.
  - IDLE resumes at t+1+2*NUM_SLOTS.
  - A scan always takes exactly 2*NUM_SLOTS cycles, whether or not events are pushed.
- FIFO write in cycle k: ev_valid/ev_data are valid from cycle k+1. No fall-through.
- ev_data is stable while ev_valid && !ev_ready.
- Repeat: the first repeat occurs REPEAT_DELAY counted IDLE cycles after the scan that armed it. Later repeats follow every REPEAT_RATE counted IDLE cycles.
- Reset asserted mid-scan or mid-repeat returns everything to reset values immediately. No events are emitted for slots not yet scanned.

## Structure
- Package keycode_pkg holds:
  - ev_type_t enum (EV_NONE=00, EV_PRESS=01, EV_RELEASE=10, EV_REPEAT=11)
  - state_t enum
  - localparam EV_W = 2+CODE_W convention
- Sub-module sync_fifo (params WIDTH, DEPTH):
  - count-based full/empty
  - registered read data
  - async active-high Reset

## Test plan
Use NUM_SLOTS=2, FIFO_DEPTH=4, REPEAT_DELAY=20, REPEAT_RATE=5.
- keycode 0x0000→0x0004 → one event {01,0x04}; any_down=1 from t+5.
- 0x0004→0x1604 → only {01,0x16}. Then →0x1600 → only {10,0x04}.
- Hold 0x0004 with ev_ready=1 → repeats {11,0x04} at 20 counted idle cycles, then every 5. Change to 0x0000 → {10,0x04} and no further repeats.
- 0x0404 (duplicate) → single {01,0x04}. Then 0x0400 → no event, since 0x04 is still present.
- ev_ready=0 while producing 5 events → FIFO holds the first 4 in order and overflow=1. Pulse ovf_clr → overflow=0. Same-cycle push/pop when full → no drop.
- Assert Reset during SCAN_PRS → outputs 0, FIFO empty. After release, the unchanged keycode 0x1604 regenerates {01,0x04} and {01,0x16}.

Source files
------------

// File: rtl/keycode_pkg.sv
// Shared types for the keycode event tracker: event type tags and scan FSM states.
package keycode_pkg;

  typedef enum logic [1:0] {
    EV_NONE    = 2'b00,
    EV_PRESS   = 2'b01,
    EV_RELEASE = 2'b10,
    EV_REPEAT  = 2'b11
  } ev_type_t;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SCAN_REL = 2'b01,
    SCAN_PRS = 2'b10
  } state_t;

  localparam int EV_TYPE_W = 2;

  // Event word is {type, code}.
  function automatic int ev_width(input int code_w);
    return EV_TYPE_W + code_w;
  endfunction

endpackage

// File: rtl/keycode_event_tracker_sync_fifo.sv
// Count-based synchronous FIFO with a registered head word (no fall-through).
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_n;
  logic [AW:0]      count, count_n, count_after_rd;
  logic             do_wr, do_rd;

  assign empty          = (count == '0);
  assign full           = (count == (AW+1)'(DEPTH));
  assign do_rd          = rd_en && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_wr          = wr_en && (!full || do_rd);
  assign rd_ptr_n       = rd_ptr + AW'(do_rd);
  assign count_after_rd = count - (AW+1)'(do_rd);
  assign count_n        = count_after_rd + (AW+1)'(do_wr);

  always_ff @(posedge Clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_wr);
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      // The head register takes the incoming word when it lands in an otherwise empty FIFO.
      if (do_wr && (count_after_rd == '0)) rd_data <= wr_data;
      else                                 rd_data <= mem[rd_ptr_n];
    end
  end

endmodule

// File: rtl/keycode_event_tracker.sv
// Turns multi-slot keycode snapshots into press/release/repeat events behind a FIFO.
module keycode_event_tracker
  import keycode_pkg::*;
#(
  parameter int NUM_SLOTS    = 2,
  parameter int CODE_W       = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 2_500_000
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [NUM_SLOTS*CODE_W-1:0]   keycode,
  output logic                          ev_valid,
  output logic [EV_TYPE_W+CODE_W-1:0]   ev_data,
  input  logic                          ev_ready,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic                          any_down
);
  localparam int EV_W    = ev_width(CODE_W);
  localparam int IDX_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

  typedef logic [NUM_SLOTS-1:0][CODE_W-1:0] snap_t;

  snap_t             prev, cur;
  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [CODE_W-1:0] rpt_code;
  logic [CNT_W-1:0]  rpt_cnt, cnt_inc;
  logic              rpt_first, armed, rpt_hit, changed;
  logic [CODE_W-1:0] scan_code;
  logic              seen_before, in_other, slot_new;
  logic              push, fifo_full, fifo_empty, drop;
  logic [EV_W-1:0]   push_data;

  assign changed = (keycode != prev);
  assign cnt_inc = rpt_cnt + 1'b1;
  assign rpt_hit = (cnt_inc == (rpt_first ? CNT_W'(REPEAT_DELAY) : CNT_W'(REPEAT_RATE)));

  // A slot is new if it is non-zero, first of its value in its own snapshot, and absent from the other.
  always_comb begin
    scan_code   = (state == SCAN_REL) ? prev[idx] : cur[idx];
    seen_before = 1'b0;
    in_other    = 1'b0;
    for (int j = 0; j < NUM_SLOTS; j++) begin
      if ((IDX_W'(j) < idx) && (((state == SCAN_REL) ? prev[j] : cur[j]) == scan_code))
        seen_before = 1'b1;
      if (((state == SCAN_REL) ? cur[j] : prev[j]) == scan_code)
        in_other = 1'b1;
    end
    slot_new = (scan_code != '0) && !seen_before && !in_other;
  end

  always_comb begin
    push      = 1'b0;
    push_data = '0;
    case (state)
      IDLE: begin
        if (!changed && armed && rpt_hit) begin
          push      = 1'b1;
          push_data = {EV_REPEAT, rpt_code};
        end
      end
      SCAN_REL: begin
        push      = slot_new;
        push_data = {EV_RELEASE, scan_code};
      end
      SCAN_PRS: begin
        push      = slot_new;
        push_data = {EV_PRESS, scan_code};
      end
      default: ;
    endcase
  end

  // Full implies non-empty, so a ready consumer always frees a slot this cycle.
  assign drop = push && fifo_full && !ev_ready;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      idx       <= '0;
      prev      <= '0;
      cur       <= '0;
      rpt_code  <= '0;
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
      armed     <= 1'b0;
      overflow  <= 1'b0;
      any_down  <= 1'b0;
    end else begin
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;

      case (state)
        IDLE: begin
          if (changed) begin
            cur   <= keycode;
            idx   <= '0;
            state <= SCAN_REL;
          end else if (armed) begin
            if (rpt_hit) begin
              rpt_cnt   <= '0;
              rpt_first <= 1'b0;
            end else begin
              rpt_cnt <= cnt_inc;
            end
          end
        end
        SCAN_REL: begin
          if (prev[idx] == rpt_code) armed <= 1'b0;
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= SCAN_PRS;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        SCAN_PRS: begin
          if (slot_new) begin
            armed     <= 1'b1;
            rpt_code  <= scan_code;
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
          end
          if (idx == LAST_IDX) begin
            prev     <= cur;
            any_down <= (cur != '0);
            idx      <= '0;
            state    <= IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk     (Clk),
    .Reset   (Reset),
    .wr_en   (push),
    .wr_data (push_data),
    .rd_en   (ev_ready),
    .rd_data (ev_data),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign ev_valid = !fifo_empty;

endmodule
